// File: rtl/btfly_sched.sv
// Radix-2 in-place FFT butterfly sequencer. Operand addresses appear the cycle after start; writeback
// trails reads by PIPE_LAT non-held cycles. i_hold freezes the sequencer and suppresses both strobes.
module btfly_sched #(
  parameter int LOG2N    = 3,
  parameter int PIPE_LAT = 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_hold,
  output logic             o_busy,
  output logic             o_done,
  output logic [LOG2N-1:0] o_stage,
  output logic             o_rd_en,
  output logic [LOG2N-1:0] o_rd_addr0,
  output logic [LOG2N-1:0] o_rd_addr1,
  output logic [LOG2N-2:0] o_tw_idx,
  output logic             o_wr_en,
  output logic [LOG2N-1:0] o_wr_addr0,
  output logic [LOG2N-1:0] o_wr_addr1
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic             en;
    logic [LOG2N-1:0] a0;
    logic [LOG2N-1:0] a1;
  } op_t;

  localparam int               TWW      = LOG2N - 1;
  localparam logic [LOG2N-1:0] S_LAST   = LOG2N'(LOG2N - 1);
  localparam logic [LOG2N-2:0] B_LAST   = '1;
  localparam logic [1:0]       CNT_LAST = 2'(PIPE_LAT - 1);

  state_t           state_q, state_d;
  logic [LOG2N-1:0] s_q, s_d;
  logic [LOG2N-2:0] b_q, b_d;
  logic [1:0]       cnt_q, cnt_d;
  op_t              iss_q, iss_d;
  logic [LOG2N-2:0] tw_q, tw_d;
  logic             rd_en_q, rd_en_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  op_t              pipe_q [PIPE_LAT];
  op_t              pipe_d [PIPE_LAT];

  logic             issue;
  logic [LOG2N-1:0] half, pos, grp, a0, a1;
  logic [TWW-1:0]   tw_full;

  // Next-state: b_q/s_q always describe the butterfly currently on the read port.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    if (state_q == DONE) begin
      state_d = IDLE;
      s_d     = '0;
      b_d     = '0;
    end else if (!i_hold) begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d = RUN;
            s_d     = '0;
            b_d     = '0;
            issue   = 1'b1;
          end
        end
        RUN: begin
          if (b_q == B_LAST) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            b_d   = b_q + 1'b1;
            issue = 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_q == CNT_LAST) begin
            if (s_q == S_LAST) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
              s_d     = s_q + 1'b1;
              b_d     = '0;
              issue   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Group base is grp * 2^(s+1); bit s of a0 is always clear, so a1 never carries out.
  always_comb begin
    half    = LOG2N'(1) << s_d;
    pos     = {1'b0, b_d} & (half - 1'b1);
    grp     = {1'b0, b_d} >> s_d;
    a0      = ((grp << s_d) << 1) + pos;
    a1      = a0 + half;
    tw_full = TWW'(pos << (S_LAST - s_d));
  end

  always_comb begin
    iss_d  = iss_q;
    tw_d   = tw_q;
    pipe_d = pipe_q;
    if (!i_hold) begin
      iss_d.en = issue;
      if (issue) begin
        iss_d.a0 = a0;
        iss_d.a1 = a1;
        tw_d     = tw_full;
      end
      pipe_d[0] = iss_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
    rd_en_d = issue;
    wr_en_d = !i_hold && pipe_d[PIPE_LAT-1].en;
    busy_d  = (state_d == RUN) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      iss_q   <= '0;
      tw_q    <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pipe_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      tw_q    <= tw_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pipe_q  <= pipe_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_stage    = s_q;
  assign o_rd_en    = rd_en_q;
  assign o_rd_addr0 = iss_q.a0;
  assign o_rd_addr1 = iss_q.a1;
  assign o_tw_idx   = tw_q;
  assign o_wr_en    = wr_en_q;
  assign o_wr_addr0 = pipe_q[PIPE_LAT-1].a0;
  assign o_wr_addr1 = pipe_q[PIPE_LAT-1].a1;

endmodule

// File: tb/tb_btfly_sched.sv
`timescale 1ns/1ps
// Two sequencers (N=8 / latency 1 and N=16 / latency 3) checked cycle by cycle against a
// slot-list model: every non-held cycle of a pass consumes one read, drain or done slot.
module tb_btfly_sched;
  localparam int K_RD = 0;
  localparam int K_DR = 1;
  localparam int K_DN = 2;

  typedef struct packed {
    int kind;
    int a0;
    int a1;
    int tw;
    int st;
  } slot_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_start, a_hold, b_start, b_hold;
  logic       a_busy, a_done, a_rd_en, a_wr_en;
  logic [2:0] a_stage, a_ra0, a_ra1, a_wa0, a_wa1;
  logic [1:0] a_tw;
  logic       b_busy, b_done, b_rd_en, b_wr_en;
  logic [3:0] b_stage, b_ra0, b_ra1, b_wa0, b_wa1;
  logic [2:0] b_tw;

  btfly_sched #(.LOG2N(3), .PIPE_LAT(1)) u_dut_a (
    .i_clock(clk), .i_reset(rst), .i_start(a_start), .i_hold(a_hold),
    .o_busy(a_busy), .o_done(a_done), .o_stage(a_stage),
    .o_rd_en(a_rd_en), .o_rd_addr0(a_ra0), .o_rd_addr1(a_ra1), .o_tw_idx(a_tw),
    .o_wr_en(a_wr_en), .o_wr_addr0(a_wa0), .o_wr_addr1(a_wa1)
  );

  btfly_sched #(.LOG2N(4), .PIPE_LAT(3)) u_dut_b (
    .i_clock(clk), .i_reset(rst), .i_start(b_start), .i_hold(b_hold),
    .o_busy(b_busy), .o_done(b_done), .o_stage(b_stage),
    .o_rd_en(b_rd_en), .o_rd_addr0(b_ra0), .o_rd_addr1(b_ra1), .o_tw_idx(b_tw),
    .o_wr_en(b_wr_en), .o_wr_addr0(b_wa0), .o_wr_addr1(b_wa1)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc   = 0;
  slot_t sl [2][64];
  int    nsl [2];
  int    lg [2] = '{3, 4};
  int    pl [2] = '{1, 3};
  int    ph [2];
  int    t [2];
  int    ndone [2];
  int    done_at [2];
  int    first_rd [2];
  int    nrd [2];
  int    hits [2][16];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic void build(input int d);
    int n, half, k, pos, base;
    n = 1 << lg[d];
    k = 0;
    for (int s = 0; s < lg[d]; s++) begin
      half = 1 << s;
      for (int b = 0; b < n / 2; b++) begin
        pos  = b % half;
        base = (b / half) * 2 * half + pos;
        sl[d][k] = '{K_RD, base, base + half, pos * ((n / 2) / half), s};
        k++;
      end
      for (int p = 0; p < pl[d]; p++) begin
        sl[d][k] = '{K_DR, 0, 0, 0, s};
        k++;
      end
    end
    sl[d][k] = '{K_DN, 0, 0, 0, 0};
    nsl[d] = k + 1;
  endfunction

  task automatic get_obs(input int d, output int busy, done, rd, wr, st, r0, r1, tw, w0, w1);
    if (d == 0) begin
      busy = int'(a_busy); done = int'(a_done); rd = int'(a_rd_en); wr = int'(a_wr_en);
      st = int'(a_stage); r0 = int'(a_ra0); r1 = int'(a_ra1); tw = int'(a_tw);
      w0 = int'(a_wa0); w1 = int'(a_wa1);
    end else begin
      busy = int'(b_busy); done = int'(b_done); rd = int'(b_rd_en); wr = int'(b_wr_en);
      st = int'(b_stage); r0 = int'(b_ra0); r1 = int'(b_ra1); tw = int'(b_tw);
      w0 = int'(b_wa0); w1 = int'(b_wa1);
    end
  endtask

  task automatic chk_zero();
    chk("rst_outs_a", int'({a_busy, a_done, a_rd_en, a_wr_en, a_stage, a_ra0, a_ra1,
                            a_tw, a_wa0, a_wa1}), 0);
    chk("rst_outs_b", int'({b_busy, b_done, b_rd_en, b_wr_en, b_stage, b_ra0, b_ra1,
                            b_tw, b_wa0, b_wa1}), 0);
  endtask

  task automatic eval_cycle(input int d, input logic st_in, input logic hd);
    int    busy, done, rd, wr, st, r0, r1, tw, w0, w1;
    int    e_busy, e_done, e_rd, e_wr;
    bit    show;
    slot_t cur, wsl;
    e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0; show = 1'b0;
    cur = '0; wsl = '0;
    if (ph[d] == 2) begin
      ph[d] = 0;
    end else if (ph[d] == 0) begin
      if (st_in && !hd) begin
        ph[d] = 1;
        t[d]  = 0;
        show  = 1'b1;
      end
    end else if (hd) begin
      e_busy = 1;
    end else begin
      t[d]++;
      show = 1'b1;
    end
    if (show) begin
      cur = sl[d][t[d]];
      if (cur.kind == K_DN) begin
        e_done = 1;
        ph[d]  = 2;
      end else begin
        e_busy = 1;
      end
      e_rd = (cur.kind == K_RD) ? 1 : 0;
      if (t[d] >= pl[d] && sl[d][t[d]-pl[d]].kind == K_RD) begin
        e_wr = 1;
        wsl  = sl[d][t[d]-pl[d]];
      end
    end
    get_obs(d, busy, done, rd, wr, st, r0, r1, tw, w0, w1);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("rd_en", rd, e_rd);
    chk("wr_en", wr, e_wr);
    if (e_rd != 0) begin
      chk("rd_addr0", r0, cur.a0);
      chk("rd_addr1", r1, cur.a1);
      chk("tw_idx", tw, cur.tw);
      chk("stage", st, cur.st);
    end
    if (e_wr != 0) begin
      chk("wr_addr0", w0, wsl.a0);
      chk("wr_addr1", w1, wsl.a1);
    end
    if (rd != 0) begin
      nrd[d]++;
      hits[d][r0]++;
      hits[d][r1]++;
      if (first_rd[d] < 0) first_rd[d] = cyc;
    end
    if (done != 0) begin
      ndone[d]++;
      done_at[d] = cyc;
    end
  endtask

  task automatic tick(input int d, input logic st_in, input logic hd);
    if (d == 0) begin
      a_start = st_in; a_hold = hd;
    end else begin
      b_start = st_in; b_hold = hd;
    end
    @(posedge clk);
    #1;
    cyc++;
    eval_cycle(d, st_in, hd);
    a_start = 1'b0; a_hold = 1'b0; b_start = 1'b0; b_hold = 1'b0;
  endtask

  task automatic run_pass(input int d, input int hold_pct, input int h_from, input int h_len,
                          input int st_at, input bit rnd_st);
    int   i, holds, s0, n;
    logic hd, st;
    n = 1 << lg[d];
    ndone[d] = 0; first_rd[d] = -1; nrd[d] = 0;
    for (int a = 0; a < 16; a++) hits[d][a] = 0;
    tick(d, 1'b1, 1'b0);
    s0 = cyc; holds = 0; i = 1;
    while (ph[d] != 0 && i < 600) begin
      hd = ((i >= h_from) && (i < h_from + h_len)) || (int'($urandom_range(0, 99)) < hold_pct);
      st = (i == st_at) || (rnd_st && ($urandom_range(0, 7) == 0));
      if (hd && ph[d] == 1) holds++;
      tick(d, st, hd);
      i++;
    end
    chk("pass_end", ph[d], 0);
    chk("first_rd", first_rd[d] - s0, 0);
    chk("done_count", ndone[d], 1);
    chk("done_lat", done_at[d] - first_rd[d], lg[d] * (n / 2 + pl[d]) + holds);
    chk("rd_count", nrd[d], lg[d] * n / 2);
    for (int a = 0; a < n; a++) chk("addr_hits", hits[d][a], lg[d]);
  endtask

  task automatic reset_mid(input int d, input int n_ticks);
    tick(d, 1'b1, 1'b0);
    for (int i = 1; i < n_ticks; i++) tick(d, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_zero();
    @(posedge clk);
    #1;
    chk_zero();
    rst = 1'b0;
    ph[0] = 0;
    ph[1] = 0;
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_hold = 1'b0; b_start = 1'b0; b_hold = 1'b0;
    for (int d = 0; d < 2; d++) begin
      build(d);
      ph[d] = 0;
      t[d]  = 0;
    end
    #3 chk_zero();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    tick(0, 1'b0, 1'b0);
    tick(0, 1'b1, 1'b1);
    tick(0, 1'b0, 1'b0);
    run_pass(0, 0, -1, 0, -1, 1'b0);
    run_pass(0, 0, 7, 3, -1, 1'b0);
    run_pass(0, 0, -1, 0, 7, 1'b0);
    run_pass(0, 0, 16, 3, -1, 1'b0);
    reset_mid(0, 6);
    run_pass(0, 0, -1, 0, -1, 1'b0);
    repeat (4) run_pass(0, 25, -1, 0, -1, 1'b1);

    run_pass(1, 0, -1, 0, -1, 1'b0);
    reset_mid(1, 10);
    run_pass(1, 0, -1, 0, -1, 1'b0);
    repeat (3) run_pass(1, 25, -1, 0, -1, 1'b1);
    tick(1, 1'b0, 1'b0);
    tick(1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/btfly_sched.md
BTFLY_SCHED -- requirements
Module: btfly_sched

Interface
REQ-001 The module SHALL have parameter LOG2N, default 3, giving the FFT size N = 2^LOG2N; the legal range is 2..10.
REQ-002 The module SHALL have parameter PIPE_LAT, default 1, giving the butterfly read-to-write latency in cycles; the legal range is 1..4.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The module SHALL have port i_clock: input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port i_reset: input, 1 bit, the asynchronous active-high reset.
REQ-006 The module SHALL have port i_start: input, 1 bit, a request to run one full in-place FFT pass.
REQ-007 The module SHALL have port i_hold: input, 1 bit, which freezes the sequencer while high.
REQ-008 The module SHALL have port o_busy: output, 1 bit, high while a pass is in progress.
REQ-009 The module SHALL have port o_done: output, 1 bit, a one-cycle pulse at the end of the pass.
REQ-010 The module SHALL have port o_stage: output, LOG2N bits, the current stage index s.
REQ-011 The module SHALL have ports o_rd_en (1 bit), o_rd_addr0 (LOG2N bits) and o_rd_addr1 (LOG2N bits): the read strobe and the two butterfly operand addresses.
REQ-012 The module SHALL have port o_tw_idx: output, LOG2N-1 bits, the twiddle ROM index.
REQ-013 The module SHALL have ports o_wr_en (1 bit), o_wr_addr0 (LOG2N bits) and o_wr_addr1 (LOG2N bits): the writeback strobe and the two writeback addresses.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, DRAIN and DONE.
REQ-015 In IDLE, i_start=1 with i_hold=0 SHALL move the FSM to RUN with s=0 and b=0; i_start SHALL be ignored in every other state.
REQ-016 In RUN, each non-held cycle SHALL assert o_rd_en and issue butterfly b of stage s, then increment b.
REQ-017 After b = N/2-1 is issued, the FSM SHALL enter DRAIN.
REQ-018 Address generation SHALL be: half = 2^s; pos = b mod half; grp = b >> s; o_rd_addr0 = grp*2*half + pos; o_rd_addr1 = o_rd_addr0 + half; o_tw_idx = pos << (LOG2N-1-s).
REQ-019 All address arithmetic SHALL be unsigned at LOG2N bits; no value ever wraps, and an implementation that wraps is defective.
REQ-020 o_wr_en, o_wr_addr0 and o_wr_addr1 SHALL equal o_rd_en, o_rd_addr0 and o_rd_addr1 delayed by exactly PIPE_LAT non-held cycles, through a shift pipeline.
REQ-021 DRAIN SHALL last exactly PIPE_LAT non-held cycles with o_rd_en=0; the last writeback of a stage occurs inside DRAIN.
REQ-022 On leaving DRAIN, the FSM SHALL go to RUN with s+1 and b=0 if s < LOG2N-1, and to DONE otherwise.
REQ-023 DONE SHALL last one cycle with o_done=1 and o_busy=0, then return to IDLE.
REQ-024 o_busy SHALL be 1 exactly in RUN and DRAIN.
REQ-025 With no hold, the first o_rd_en SHALL be at cycle k+1 for i_start sampled at edge k, and o_done SHALL be at cycle k+1+LOG2N*(N/2+PIPE_LAT).
REQ-026 i_hold=1 SHALL freeze the state, s, b and the write pipeline, and SHALL force o_rd_en=0 and o_wr_en=0 for that cycle; address outputs hold their values.
REQ-027 i_hold asserted in DONE SHALL NOT extend or suppress o_done.
REQ-028 When i_start and i_hold are both high in IDLE, the FSM SHALL remain in IDLE.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 i_reset=1 SHALL, asynchronously, force IDLE with s=0, b=0 and the write pipeline cleared.
REQ-031 Every output SHALL be 0 while i_reset=1.
REQ-032 Reset in any state, including mid-RUN and mid-DRAIN, SHALL abort the pass with no further o_wr_en and no o_done.
REQ-033 After reset releases, the block SHALL accept i_start on the first rising edge.

Verification
REQ-034 Stage 0: LOG2N=3, PIPE_LAT=1, a single i_start pulse -> rd pairs (0,1),(2,3),(4,5),(6,7) with o_tw_idx 0,0,0,0, and o_wr_en on the same pairs one cycle later.
REQ-035 Stages 1 and 2: same run -> stage 1 pairs (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2; stage 2 pairs (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3; exactly one o_rd_en=0 drain cycle between stages; o_done at k+16; o_busy high from k+1 to k+15.
REQ-036 Hold: i_hold=1 for 3 cycles after the second read of stage 1 -> no strobes during the hold, the sequence resumes at pair (4,6) unchanged, and o_done is delayed by exactly 3 cycles.
REQ-037 Ignored start: i_start pulsed at k+7 during busy -> no effect, and exactly one o_done.
REQ-038 Reset mid-stage: i_reset pulsed at k+6 -> all outputs 0 immediately, no o_done; a new i_start then gives the full stage 0 sequence again.
REQ-039 Parameter sweep: LOG2N=4 and PIPE_LAT=3 -> 32 reads, each address read exactly twice per stage pair set, and o_done at k+1+4*(8+3) = k+45.
